kypd_event_queue: RTL
=====================

KYPD_EVENT_QUEUE -- requirements
Module: kypd_event_queue

Interface
REQ-001 SHALL have parameter STABLE_SAMPLES, default 3, range 1..7: consecutive identical scan samples required to accept a button state.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries.
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, default 3: log2 of FIFO_DEPTH.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge; one clock domain.
REQ-005 SHALL have port rstn, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port btn_in, input, 25: active-high scanned button vector, bit index = row*5 + col.
REQ-007 SHALL have port btn_ready, input, 1: one-cycle strobe; btn_in valid when high.
REQ-008 SHALL have port evt_data, output, 6: {press, code[4:0]}; press=1 for press, 0 for release.
REQ-009 SHALL have port evt_valid, output, 1: FIFO head valid.
REQ-010 SHALL have port evt_ready, input, 1: consumer accepts head.
REQ-011 SHALL have port pressed, output, 25: debounced button state.
REQ-012 SHALL have port fifo_count, output, FIFO_DEPTH_LOG2+1: stored entries.
REQ-013 SHALL have port overflow, output, 1: sticky lost-event flag.
REQ-014 SHALL have port clr_overflow, input, 1: clears overflow.

Function
REQ-015 SHALL per button i keep raw_last[i] and a 3-bit saturating stab_cnt[i], updated only on cycles with btn_ready=1.
REQ-016 SHALL on btn_ready with btn_in[i]==raw_last[i] increment stab_cnt[i], saturating at STABLE_SAMPLES; otherwise load raw_last[i]=btn_in[i], stab_cnt[i]=1.
REQ-017 SHALL, on the same edge, set pressed[i]=raw_last-candidate and flag a change when the updated stab_cnt[i] equals STABLE_SAMPLES and the candidate differs from pressed[i]; STABLE_SAMPLES=1 accepts every differing sample.
REQ-018 SHALL on a change set pending[i]; if pending[i] already set, clear pending[i] (events cancel) and set overflow.
REQ-019 SHALL each cycle, when pending!=0 and FIFO not full, clear the lowest-index pending bit i and push {pressed[i], i}; one push per cycle maximum.
REQ-020 SHALL stall the scanner while FIFO full; pending bits held, no loss.
REQ-021 SHALL give latency: btn_ready at edge N completes stability -> push at edge N+1 -> evt_valid=1 after edge N+1 (FIFO empty, lowest pending).
REQ-022 SHALL implement FIFO first-word-fall-through: evt_valid = (fifo_count!=0), evt_data = head entry, combinationally from registers.
REQ-023 SHALL pop on evt_valid && evt_ready; push+pop same cycle leaves fifo_count unchanged.
REQ-024 SHALL evaluate full at cycle start: no push when fifo_count==FIFO_DEPTH even if popping that cycle.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH nor underflows.
REQ-026 SHALL clear overflow on clr_overflow; a set in the same cycle wins.
REQ-027 SHALL ignore btn_in when btn_ready=0.

Reset
REQ-028 SHALL on rstn=0 at a clock edge set pressed=0, raw_last=0, stab_cnt=STABLE_SAMPLES, pending=0, pointers=0, fifo_count=0, overflow=0, evt_data=0; no events generated by reset or first samples of all-released.
REQ-029 SHALL discard stored and pending events on reset mid-operation; evt_valid=0 the cycle after reset is sampled.

Verification
REQ-030 SHALL test: btn_in[7]=1 for 3 strobes -> one event 6'h27, pressed[7]=1; then 0 for 3 strobes -> event 6'h07.
REQ-031 SHALL test bounce: bit 2 sequence 1,0,1,1,1 over 5 strobes -> single event 6'h22 after fifth strobe only.
REQ-032 SHALL test: bits 0,5,24 stable together, evt_ready=1 -> events 6'h20, 6'h25, 6'h38 on consecutive cycles.
REQ-033 SHALL test: evt_ready=0, buttons 0..9 pressed together -> fifo_count=8, evt_valid=1, overflow=0; then evt_ready=1 -> 10 events codes 0..9 in order.
REQ-034 SHALL test: FIFO full, button 3 press pending then release accepted -> no events for code 3, overflow=1 until clr_overflow pulse.
REQ-035 SHALL test: rstn=0 for one edge with fifo_count=4 -> fifo_count=0, evt_valid=0, pressed=0, overflow=0.

Source files
------------

// File: rtl/kypd_event_queue.sv
// kypd_event_queue: debounced 5x5 keypad scanner feeding a first-word-fall-through event FIFO.
// Accepted state changes are latched as pending bits and then drained into the FIFO, lowest index first.

module kypd_debounce #(
    parameter int N              = 25,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] btn_in,
    input  logic         btn_ready,
    output logic [N-1:0] pressed,
    output logic [N-1:0] change
);
    localparam logic [2:0] STABLE = 3'(STABLE_SAMPLES);

    logic [N-1:0]       raw_last;
    logic [N-1:0]       raw_nxt;
    logic [N-1:0]       pressed_nxt;
    logic [N-1:0][2:0]  stab_cnt;
    logic [N-1:0][2:0]  cnt_nxt;

    always_comb begin
        raw_nxt     = raw_last;
        pressed_nxt = pressed;
        cnt_nxt     = stab_cnt;
        change      = '0;
        for (int i = 0; i < N; i++) begin
            if (btn_ready) begin
                if (btn_in[i] == raw_last[i]) begin
                    cnt_nxt[i] = (stab_cnt[i] >= STABLE) ? STABLE
                                                         : stab_cnt[i] + 3'd1;
                end else begin
                    raw_nxt[i] = btn_in[i];
                    cnt_nxt[i] = 3'd1;
                end
                // Accept the candidate once it has been seen enough times in a row
                if (cnt_nxt[i] == STABLE && raw_nxt[i] != pressed[i]) begin
                    change[i]      = 1'b1;
                    pressed_nxt[i] = raw_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            raw_last <= '0;
            pressed  <= '0;
            for (int i = 0; i < N; i++) begin
                stab_cnt[i] <= STABLE;
            end
        end else begin
            raw_last <= raw_nxt;
            pressed  <= pressed_nxt;
            stab_cnt <= cnt_nxt;
        end
    end
endmodule

module kypd_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
            end
            unique case (1'b1)
                push && !pop: count <= count + 1'b1;
                pop && !push: count <= count - 1'b1;
                default:      count <= count;
            endcase
        end
    end
endmodule

module kypd_event_queue #(
    parameter int STABLE_SAMPLES  = 3,
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [24:0]              btn_in,
    input  logic                     btn_ready,
    output logic [5:0]               evt_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [24:0]              pressed,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow,
    input  logic                     clr_overflow
);
    logic [24:0] change;
    logic [24:0] pending;
    logic [24:0] pending_base;
    logic [24:0] drain_mask;
    logic [4:0]  sel;
    logic        found;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        ovf_set;
    logic [5:0]  push_data;

    kypd_debounce #(
        .N              (25),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_deb (
        .clk       (clk),
        .rstn      (rstn),
        .btn_in    (btn_in),
        .btn_ready (btn_ready),
        .pressed   (pressed),
        .change    (change)
    );

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (!found && pending[i]) begin
                sel   = 5'(i);
                found = 1'b1;
            end
        end
    end

    // Fullness is judged on the registered count, so a pop cannot free a slot for this cycle
    assign push       = found && !full;
    assign pop        = !empty && evt_ready;
    assign push_data  = {pressed[sel], sel};
    assign drain_mask = push ? (25'd1 << sel) : '0;

    // A second change before the first was queued cancels both
    assign pending_base = pending & ~drain_mask;
    assign ovf_set      = |(change & pending_base);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_base ^ change;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    kypd_fifo #(
        .W     (6),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (evt_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign evt_valid = !empty;
endmodule
